// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder built from one DIGIT-bit slice, DIGIT bits/clock.
// Optional subtract mode when SERIAL_ADDER_SUB_EN is defined (adds port sub).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             last;

  // Operand conditioning at start: subtract is a + ~b + 1.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_in = sub ? ~b : b;
    c_in = sub ? 1'b1 : cin;
`else
    b_in = b;
    c_in = cin;
`endif
  end

  // One DIGIT-bit full-adder slice on the low chunk of the operands.
  always_comb begin
    slice = {1'b0, a_q[DIGIT-1:0]}
          + {1'b0, b_q[DIGIT-1:0]}
          + {{DIGIT{1'b0}}, carry_q};
    last  = (cnt_q == CW'(N - 1));
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = c_in;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d = slice[DIGIT];
        sum_d   = (sum_q >> DIGIT)
                | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          cout_d  = slice[DIGIT];
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any add in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised successor to the combinational half/full adders.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through one DIGIT-bit full-adder slice and a registered carry.
- Uses a start/ready/done handshake, so wide adds can be built from a narrow datapath.

Parameters:
- WIDTH, 8: operand and sum width in bits. Must be an integer multiple of DIGIT.
- DIGIT, 1: bits processed per clock, 1..WIDTH. DIGIT=WIDTH gives a one-cycle add.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new add. Accepted only when ready=1.
- a  input  WIDTH  operand A, sampled on the accepted start.
- b  input  WIDTH  operand B, sampled on the accepted start.
- cin  input  1  carry-in, sampled on the accepted start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result; held from done until the next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, done=0, sum=0, cout=0, chunk counter=0, internal operand and carry registers=0.
- Reset mid-operation aborts the add. No done pulse is produced. rst has priority over start.
- Number of chunks: N = WIDTH/DIGIT.
- IDLE:
  - ready=1.
  - At an edge with start=1: latch a→A_reg, b→B_reg, cin→carry. Clear sum and cout. Counter=0. Go to RUN.
  - start=0: stay in IDLE, outputs held.
- RUN (ready=0), at each edge:
  - Compute {c, s} = A_reg[DIGIT-1:0] + B_reg[DIGIT-1:0] + carry, with DIGIT+1 bits of width.
  - carry←c.
  - Shift s into sum from the MSB end: sum ← {s, sum[WIDTH-1:DIGIT]}.
  - Shift A_reg and B_reg right by DIGIT.
  - Increment the counter.
  - On the edge that processes chunk N-1: cout←c, go to DONE.
- DONE (ready=0): done=1 for exactly this one cycle. Next edge goes to IDLE. sum/cout unchanged.
- Latency: start sampled at edge k → done high in the cycle after edge k+N. The next start can be accepted at edge k+N+2 at the earliest.
- start while ready=0 is ignored, with no queuing. Changes to a/b/cin after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. cout = bit WIDTH of a+b+cin.
- Wrap case: a=all-ones, b=0, cin=1 → sum=0, cout=1.
- Outputs are all registered. No combinational path from inputs to outputs except none (ready depends on state only).

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled with start.
  - sub=1: B_reg latched as ~b, initial carry forced to 1 (cin ignored). The result is a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned); cout=0 means borrow.
  - sub=0: identical to the base behaviour.
- Not defined: no sub port. The block is add-only, exactly as described above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 → ready=1, done=0, sum=0x00, cout=0, stable for 20 cycles.
- WIDTH=8, DIGIT=1, a=0xFF, b=0x01, cin=0, start at edge k → done high only in the cycle after edge k+8, sum=0x00, cout=1. ready=0 from k+1 to k+9, and 1 again after k+9.
- WIDTH=8, DIGIT=4, a=0x5A, b=0x3C, cin=1 → done after edge k+2, sum=0x97, cout=0. Repeat with DIGIT=8 → done after edge k+1, same result.
- Ignored start and held results, WIDTH=8, DIGIT=1:
  - Issue start with a=0x12, b=0x34.
  - During RUN, change a/b to 0xAA and pulse start → result is still sum=0x46, cout=0, with exactly one done pulse.
  - sum stays 0x46 until the next accepted start.
- Reset mid-op: rst=1 four cycles after start → next cycle ready=1, sum=0, cout=0, and no done pulse. A fresh add of 0x01+0x01 then gives 0x02.
- With SERIAL_ADDER_SUB_EN, WIDTH=8:
  - sub=1, a=0x10, b=0x20 → sum=0xF0, cout=0.
  - sub=1, a=0x20, b=0x10 → sum=0x10, cout=1.
  - sub=0 with 0x5A+0x3C, cin=0 → 0x96.
